ysyx_22040759_mul_ctrl: RTL

YSYX_22040759_MUL_CTRL -- requirements
Module: ysyx_22040759_mul_ctrl

---
 rtl/ysyx_22040759_mul_ctrl_pkg.sv | 25 ++
 rtl/ysyx_22040759_mul_fmt.sv | 17 +
 rtl/ysyx_22040759_mul_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/ysyx_22040759_mul_ctrl_pkg.sv
// ysyx_22040759_mul_ctrl_pkg: shared funct3 op codes, FSM states and mul_signed codes
// for the M-extension multiply controller.
package ysyx_22040759_mul_ctrl_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] sgn_of(input logic [1:0] op);
        return (op == OP_MULHU) ? SGN_UU : (op == OP_MULHSU) ? SGN_SU : SGN_SS;
    endfunction

endpackage

// File: rtl/ysyx_22040759_mul_fmt.sv
// ysyx_22040759_mul_fmt: selects and formats the writeback word from the product halves.
module ysyx_22040759_mul_fmt
    import ysyx_22040759_mul_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_op,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    output logic [XLEN-1:0] o_data
);

    assign o_data = i_word ? {{(XLEN-32){i_lo[31]}}, i_lo[31:0]} :
                    (i_op == OP_MUL) ? i_lo : i_hi;

endmodule

// File: rtl/ysyx_22040759_mul_ctrl.sv
// ysyx_22040759_mul_ctrl: EX-stage multiply controller (IDLE/ISSUE/WAIT/DONE handshake FSM).
// Define YSYX_22040759_MUL_ZERO_SKIP_EN to complete zero-operand ops without the multiplier.
module ysyx_22040759_mul_ctrl
    import ysyx_22040759_mul_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [1:0]      ex_op,
    input  logic            ex_word,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_src2,
    output logic            ex_ready,
    input  logic            flush,
    output logic            mul_valid,
    output logic            mulw,
    output logic            mul_flush,
    output logic [1:0]      mul_signed,
    output logic [XLEN-1:0] multiplicand,
    output logic [XLEN-1:0] multiplier,
    input  logic            mul_ready,
    input  logic            mul_out_valid,
    input  logic [XLEN-1:0] mul_result_hi,
    input  logic [XLEN-1:0] mul_result_lo,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    input  logic            wb_ready
);

    state_t            r_state, w_next;
    logic [1:0]        r_op, r_sgn;
    logic              r_mulw;
    logic [XLEN-1:0]   r_mcand, r_mplier, r_wb_data;
    logic              w_accept, w_skip;
    logic [XLEN-1:0]   w_fmt;

    assign w_accept = (r_state == S_IDLE) && ex_valid && !flush;

`ifdef YSYX_22040759_MUL_ZERO_SKIP_EN
    assign w_skip = ex_word ? (ex_src1[31:0] == 32'd0 || ex_src2[31:0] == 32'd0)
                            : (ex_src1 == '0 || ex_src2 == '0);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_skip ? S_DONE : S_ISSUE) : S_IDLE;
            S_ISSUE: w_next = mul_ready ? S_WAIT : S_ISSUE;
            S_WAIT:  w_next = mul_out_valid ? S_DONE : S_WAIT;
            default: w_next = wb_ready ? S_IDLE : S_DONE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_MUL;
            r_sgn     <= SGN_UU;
            r_mulw    <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op     <= ex_op;
                r_sgn    <= sgn_of(ex_op);
                r_mulw   <= ex_word && (ex_op == OP_MUL);
                r_mcand  <= ex_src1;
                r_mplier <= ex_src2;
                if (w_skip) r_wb_data <= '0;
            end
            // a result arriving with flush belongs to the killed op
            if (r_state == S_WAIT && mul_out_valid && !flush) r_wb_data <= w_fmt;
        end
    end

    ysyx_22040759_mul_fmt #(.XLEN(XLEN)) u_fmt (
        .i_op   (r_op),
        .i_word (r_mulw),
        .i_hi   (mul_result_hi),
        .i_lo   (mul_result_lo),
        .o_data (w_fmt)
    );

    assign ex_ready     = (r_state == S_IDLE);
    assign mul_valid    = (r_state == S_ISSUE);
    assign mul_flush    = flush && (r_state == S_ISSUE || r_state == S_WAIT);
    assign wb_valid     = (r_state == S_DONE);
    assign wb_data      = r_wb_data;
    assign mul_signed   = r_sgn;
    assign mulw         = r_mulw;
    assign multiplicand = r_mcand;
    assign multiplier   = r_mplier;

endmodule
